// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rv_pkg
//  Purpose  : Shared RV64 decode definitions: datapath width, major opcode
//             constants, the immediate-format enum and a helper that maps an
//             opcode onto its immediate format.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package rv_pkg;

    localparam int XLEN = 64;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;

    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_S    = 3'd1,
        IMM_B    = 3'd2,
        IMM_U    = 3'd3,
        IMM_J    = 3'd4,
        IMM_NONE = 3'd5
    } imm_type_t;

    function automatic imm_type_t imm_type_of(input logic [6:0] opcode);
        imm_type_t t;
        case (opcode)
            OP_LOAD, OP_IMM, OP_IMM32, OP_JALR: t = IMM_I;
            OP_STORE:                           t = IMM_S;
            OP_BRANCH:                          t = IMM_B;
            OP_LUI, OP_AUIPC:                   t = IMM_U;
            OP_JAL:                             t = IMM_J;
            default:                            t = IMM_NONE;
        endcase
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : decode_stage_if
//  Purpose  : Bundles the fetch input, flush, write-back and ID/EX output
//             signals of the decode stage.
//  Modports : master - fetch/EX/WB side (drives if_*, flush, wb_*)
//             slave  - decode stage (drives hazard_stall and ex_*)
//  Revision : 1.0  initial release
// ============================================================================
interface decode_stage_if #(
    parameter int XLEN = rv_pkg::XLEN
);
    logic [XLEN-1:0] if_pc;
    logic [31:0]     if_instruction;
    logic            if_valid;
    logic            flush;
    logic            wb_en;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;

    logic            hazard_stall;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_rs1_data;
    logic [XLEN-1:0] ex_rs2_data;
    logic [XLEN-1:0] ex_imm;
    logic [4:0]      ex_rs1;
    logic [4:0]      ex_rs2;
    logic [4:0]      ex_rd;
    logic [6:0]      ex_opcode;
    logic [2:0]      ex_funct3;
    logic            ex_funct7b5;
    logic            ex_mem_read;

    modport master (
        output if_pc, if_instruction, if_valid, flush, wb_en, wb_rd, wb_data,
        input  hazard_stall, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_opcode, ex_funct3, ex_funct7b5, ex_mem_read
    );

    modport slave (
        input  if_pc, if_instruction, if_valid, flush, wb_en, wb_rd, wb_data,
        output hazard_stall, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_opcode, ex_funct3, ex_funct7b5, ex_mem_read
    );

endinterface
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file
//  Purpose  : NREGS x XLEN architectural register file, two read ports and
//             one write port. x0 is hardwired to zero; a write-back in the
//             same cycle as a read of the same register is forwarded.
//  Ports    : Clk, reset         - clock, async active-high reset
//             i_rs1_addr/i_rs2_addr - read addresses
//             o_rs1_data/o_rs2_data - read data (combinational)
//             i_wb_en/i_wb_rd/i_wb_data - write port
//  Revision : 1.0  initial release
// ============================================================================
module reg_file #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32
) (
    input  wire logic            Clk,
    input  wire logic            reset,
    input  wire logic [4:0]      i_rs1_addr,
    input  wire logic [4:0]      i_rs2_addr,
    output logic      [XLEN-1:0] o_rs1_data,
    output logic      [XLEN-1:0] o_rs2_data,
    input  wire logic            i_wb_en,
    input  wire logic [4:0]      i_wb_rd,
    input  wire logic [XLEN-1:0] i_wb_data
);

    logic [XLEN-1:0] r_regs [NREGS];
    logic            w_wb_active;

    // Writes to x0 are dropped, so x0 never leaves its reset value.
    assign w_wb_active = i_wb_en && (i_wb_rd != 5'd0);

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb_active) begin
            r_regs[i_wb_rd] <= i_wb_data;
        end
    end

    // x0 check comes first so a stray x0 write-back is never forwarded.
    always_comb begin
        o_rs1_data = r_regs[i_rs1_addr];
        if (i_rs1_addr == 5'd0) begin
            o_rs1_data = '0;
        end else if (w_wb_active && (i_wb_rd == i_rs1_addr)) begin
            o_rs1_data = i_wb_data;
        end
    end

    always_comb begin
        o_rs2_data = r_regs[i_rs2_addr];
        if (i_rs2_addr == 5'd0) begin
            o_rs2_data = '0;
        end else if (w_wb_active && (i_wb_rd == i_rs2_addr)) begin
            o_rs2_data = i_wb_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : decode_stage
//  Purpose  : RV64 instruction-decode stage: IF/ID latch, register read with
//             write-back bypass, immediate generation, load-use hazard
//             detection and the ID/EX output register.
//  Ports    : Clk   - clock, rising edge
//             reset - asynchronous active-high reset
//             bus   - decode_stage_if.slave: fetch inputs (if_*), flush,
//                     write-back (wb_*), hazard_stall and the ID/EX fields
//  Revision : 1.0  initial release
// ============================================================================
module decode_stage #(
    parameter int XLEN  = rv_pkg::XLEN,
    parameter int NREGS = 32
) (
    input  wire logic     Clk,
    input  wire logic     reset,
    decode_stage_if.slave bus
);

    import rv_pkg::*;

    // IF/ID latch
    logic            r_ifid_valid;
    logic [XLEN-1:0] r_ifid_pc;
    logic [31:0]     r_ifid_instr;

    // Decoded fields
    logic [6:0]      w_opcode;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [4:0]      w_rd;
    logic [2:0]      w_funct3;
    logic            w_funct7b5;
    imm_type_t       w_imm_type;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;
    logic            w_uses_rs2;
    logic            w_hazard_stall;

    // ID/EX register
    logic            r_ex_valid;
    logic [XLEN-1:0] r_ex_pc;
    logic [XLEN-1:0] r_ex_rs1_data;
    logic [XLEN-1:0] r_ex_rs2_data;
    logic [XLEN-1:0] r_ex_imm;
    logic [4:0]      r_ex_rs1;
    logic [4:0]      r_ex_rs2;
    logic [4:0]      r_ex_rd;
    logic [6:0]      r_ex_opcode;
    logic [2:0]      r_ex_funct3;
    logic            r_ex_funct7b5;
    logic            r_ex_mem_read;

    // ------------------------------------------------------------------
    // IF/ID latch: holds while stalled; flush kills the valid bit even
    // while stalled, so the stalled instruction is discarded.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_ifid_valid <= 1'b0;
            r_ifid_pc    <= '0;
            r_ifid_instr <= '0;
        end else begin
            if (!w_hazard_stall) begin
                r_ifid_valid <= bus.if_valid;
                r_ifid_pc    <= bus.if_pc;
                r_ifid_instr <= bus.if_instruction;
            end
            if (bus.flush) begin
                r_ifid_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Field extraction and immediate generation
    // ------------------------------------------------------------------
    assign w_opcode   = r_ifid_instr[6:0];
    assign w_rd       = r_ifid_instr[11:7];
    assign w_funct3   = r_ifid_instr[14:12];
    assign w_rs1      = r_ifid_instr[19:15];
    assign w_rs2      = r_ifid_instr[24:20];
    assign w_funct7b5 = r_ifid_instr[30];
    assign w_imm_type = imm_type_of(w_opcode);

    // Every format carries its sign in instruction bit 31.
    always_comb begin
        w_imm = '0;
        case (w_imm_type)
            IMM_I: w_imm = {{(XLEN-12){r_ifid_instr[31]}}, r_ifid_instr[31:20]};
            IMM_S: w_imm = {{(XLEN-12){r_ifid_instr[31]}}, r_ifid_instr[31:25],
                            r_ifid_instr[11:7]};
            IMM_B: w_imm = {{(XLEN-13){r_ifid_instr[31]}}, r_ifid_instr[31],
                            r_ifid_instr[7], r_ifid_instr[30:25],
                            r_ifid_instr[11:8], 1'b0};
            IMM_U: w_imm = {{(XLEN-32){r_ifid_instr[31]}}, r_ifid_instr[31:12],
                            12'b0};
            IMM_J: w_imm = {{(XLEN-21){r_ifid_instr[31]}}, r_ifid_instr[31],
                            r_ifid_instr[19:12], r_ifid_instr[20],
                            r_ifid_instr[30:21], 1'b0};
            default: w_imm = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    reg_file #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_reg_file (
        .Clk        (Clk),
        .reset      (reset),
        .i_rs1_addr (w_rs1),
        .i_rs2_addr (w_rs2),
        .o_rs1_data (w_rs1_data),
        .o_rs2_data (w_rs2_data),
        .i_wb_en    (bus.wb_en),
        .i_wb_rd    (bus.wb_rd),
        .i_wb_data  (bus.wb_data)
    );

    // ------------------------------------------------------------------
    // Load-use hazard. The rs2 field is only a real source for R-type,
    // store and branch; for I/U/J formats those bits are immediate and must
    // not trigger a false stall.
    // ------------------------------------------------------------------
    assign w_uses_rs2 = (w_opcode == OP_REG)   || (w_opcode == OP_REG32) ||
                        (w_opcode == OP_STORE) || (w_opcode == OP_BRANCH);

    assign w_hazard_stall = r_ifid_valid && r_ex_valid && r_ex_mem_read &&
                            (r_ex_rd != 5'd0) &&
                            ((r_ex_rd == w_rs1) || ((r_ex_rd == w_rs2) && w_uses_rs2));

    // ------------------------------------------------------------------
    // ID/EX register. Fields load every cycle; a bubble is expressed only
    // through ex_valid, so the hazard check above must always qualify on it.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_ex_valid    <= 1'b0;
            r_ex_pc       <= '0;
            r_ex_rs1_data <= '0;
            r_ex_rs2_data <= '0;
            r_ex_imm      <= '0;
            r_ex_rs1      <= '0;
            r_ex_rs2      <= '0;
            r_ex_rd       <= '0;
            r_ex_opcode   <= '0;
            r_ex_funct3   <= '0;
            r_ex_funct7b5 <= 1'b0;
            r_ex_mem_read <= 1'b0;
        end else begin
            r_ex_valid    <= (bus.flush || w_hazard_stall) ? 1'b0 : r_ifid_valid;
            r_ex_pc       <= r_ifid_pc;
            r_ex_rs1_data <= w_rs1_data;
            r_ex_rs2_data <= w_rs2_data;
            r_ex_imm      <= w_imm;
            r_ex_rs1      <= w_rs1;
            r_ex_rs2      <= w_rs2;
            r_ex_rd       <= w_rd;
            r_ex_opcode   <= w_opcode;
            r_ex_funct3   <= w_funct3;
            r_ex_funct7b5 <= w_funct7b5;
            r_ex_mem_read <= (w_opcode == OP_LOAD);
        end
    end

    assign bus.hazard_stall = w_hazard_stall;
    assign bus.ex_valid     = r_ex_valid;
    assign bus.ex_pc        = r_ex_pc;
    assign bus.ex_rs1_data  = r_ex_rs1_data;
    assign bus.ex_rs2_data  = r_ex_rs2_data;
    assign bus.ex_imm       = r_ex_imm;
    assign bus.ex_rs1       = r_ex_rs1;
    assign bus.ex_rs2       = r_ex_rs2;
    assign bus.ex_rd        = r_ex_rd;
    assign bus.ex_opcode    = r_ex_opcode;
    assign bus.ex_funct3    = r_ex_funct3;
    assign bus.ex_funct7b5  = r_ex_funct7b5;
    assign bus.ex_mem_read  = r_ex_mem_read;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decode_stage
//  Purpose  : Self-checking bench for decode_stage. Issued instructions push
//             their expected ID/EX contents into a queue; a monitor pops and
//             compares whenever ex_valid is high. Bubbles, stalls and reset
//             behaviour are checked inline by each scenario task.
//  Revision : 1.0  initial release
// ============================================================================
module tb_decode_stage;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] rs1_data;
        logic [63:0] rs2_data;
        logic [63:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic        mem_read;
    } ex_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests;
    int   n_fail;
    bit   sb_on;
    ex_t  exp_q[$];
    ex_t  exp_e;
    ex_t  obs_e;

    always #5 clk = ~clk;

    decode_stage_if #(.XLEN(64)) bus ();

    decode_stage #(
        .XLEN  (64),
        .NREGS (32)
    ) dut (
        .Clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    // Encodings
    localparam logic [31:0] I_ADDI_X1_M1  = 32'hFFF0_0093; // addi x1,x0,-1
    localparam logic [31:0] I_SD_X2_8_X1  = 32'h0020_B423; // sd x2,8(x1)
    localparam logic [31:0] I_BEQ_M4      = 32'hFE20_8EE3; // beq x1,x2,-4
    localparam logic [31:0] I_LUI_X3      = 32'h8000_01B7; // lui x3,0x80000
    localparam logic [31:0] I_ADD_X8_X7   = 32'h0003_8433; // add x8,x7,x0
    localparam logic [31:0] I_ADD_X8_X5   = 32'h0002_8433; // add x8,x5,x0
    localparam logic [31:0] I_ADD_X9_X0   = 32'h0000_04B3; // add x9,x0,x0
    localparam logic [31:0] I_ADD_X10_X7  = 32'h0070_0533; // add x10,x0,x7
    localparam logic [31:0] I_LD_X5       = 32'h0000_B283; // ld x5,0(x1)
    localparam logic [31:0] I_ADD_X6_X5   = 32'h0022_8333; // add x6,x5,x2
    localparam logic [31:0] I_ADDI_X11    = 32'h00B0_0593; // addi x11,x0,11

    function automatic ex_t mk(input logic [63:0] pc, input logic [31:0] ins,
                               input logic [63:0] imm, input logic [63:0] d1,
                               input logic [63:0] d2);
        ex_t e;
        e.pc       = pc;
        e.rs1_data = d1;
        e.rs2_data = d2;
        e.imm      = imm;
        e.rs1      = ins[19:15];
        e.rs2      = ins[24:20];
        e.rd       = ins[11:7];
        e.opcode   = ins[6:0];
        e.funct3   = ins[14:12];
        e.funct7b5 = ins[30];
        e.mem_read = (ins[6:0] == 7'b0000011);
        return e;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [63:0] pc, input logic [31:0] ins);
        bus.if_pc          = pc;
        bus.if_instruction = ins;
        bus.if_valid       = 1'b1;
    endtask

    task automatic idle();
        bus.if_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            cycle();
            k++;
        end
    endtask

    // Scoreboard monitor
    always @(posedge clk) begin
        #1;
        if (sb_on && bus.ex_valid === 1'b1) begin
            n_tests++;
            obs_e = '{pc: bus.ex_pc, rs1_data: bus.ex_rs1_data, rs2_data: bus.ex_rs2_data,
                      imm: bus.ex_imm, rs1: bus.ex_rs1, rs2: bus.ex_rs2, rd: bus.ex_rd,
                      opcode: bus.ex_opcode, funct3: bus.ex_funct3,
                      funct7b5: bus.ex_funct7b5, mem_read: bus.ex_mem_read};
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected ex_pc=%h got valid=1 required no issue", bus.ex_pc);
            end else begin
                exp_e = exp_q.pop_front();
                if (obs_e !== exp_e) begin
                    n_fail++;
                    $display("FAIL sb_ex pc=%h got=%h required=%h", exp_e.pc, obs_e, exp_e);
                end
            end
        end
    end

    task automatic test_reset();
        n_tests++;
        if ({bus.ex_valid, bus.ex_pc, bus.ex_imm, bus.ex_rd, bus.ex_mem_read,
             bus.ex_rs1_data, bus.hazard_stall} !== '0) begin
            n_fail++;
            $display("FAIL reset_state ex_valid=%b ex_pc=%h stall=%b required all 0",
                     bus.ex_valid, bus.ex_pc, bus.hazard_stall);
        end
        rst = 1'b0;
        sb_on = 1'b0;
        // Write x5 and build a load-use stall, then reset mid-cycle.
        bus.wb_en = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 64'h55;
        present(64'h100, I_LD_X5);
        cycle();
        bus.wb_en = 1'b0;
        present(64'h104, I_ADD_X6_X5);
        cycle();
        n_tests++;
        if (bus.hazard_stall !== 1'b1 || bus.ex_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_prestall stall=%b ex_valid=%b required 1 1",
                     bus.hazard_stall, bus.ex_valid);
        end
        #1 rst = 1'b1;
        #1;
        n_tests++;
        if ({bus.ex_valid, bus.ex_pc, bus.ex_imm, bus.ex_rd, bus.ex_rs1,
             bus.ex_opcode, bus.ex_mem_read, bus.hazard_stall} !== '0) begin
            n_fail++;
            $display("FAIL reset_async ex_valid=%b ex_pc=%h ex_opcode=%h stall=%b required all 0",
                     bus.ex_valid, bus.ex_pc, bus.ex_opcode, bus.hazard_stall);
        end
        idle();
        cycle();
        rst = 1'b0;
        sb_on = 1'b1;
        present(64'h200, I_ADD_X8_X5);
        exp_q.push_back(mk(64'h200, I_ADD_X8_X5, 64'd0, 64'd0, 64'd0));
        cycle();
        idle();
        drain(5);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_x5_drain pending=%0d required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_immediates();
        present(64'h10, I_ADDI_X1_M1);
        exp_q.push_back(mk(64'h10, I_ADDI_X1_M1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0));
        cycle();
        present(64'h14, I_SD_X2_8_X1);
        exp_q.push_back(mk(64'h14, I_SD_X2_8_X1, 64'd8, 64'd0, 64'd0));
        cycle();
        present(64'h18, I_BEQ_M4);
        exp_q.push_back(mk(64'h18, I_BEQ_M4, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 64'd0));
        cycle();
        present(64'h1C, I_LUI_X3);
        exp_q.push_back(mk(64'h1C, I_LUI_X3, 64'hFFFF_FFFF_8000_0000, 64'd0, 64'd0));
        cycle();
        idle();
        drain(6);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL imm_drain pending=%0d required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_bypass_x0();
        present(64'h40, I_ADD_X8_X7);
        exp_q.push_back(mk(64'h40, I_ADD_X8_X7, 64'd0, 64'h1234, 64'd0));
        cycle();
        // add is in IF/ID now: write-back to x7 in the same cycle as its read
        idle();
        bus.wb_en = 1'b1; bus.wb_rd = 5'd7; bus.wb_data = 64'h1234;
        cycle();
        bus.wb_en = 1'b0;
        present(64'h44, I_ADD_X9_X0);
        exp_q.push_back(mk(64'h44, I_ADD_X9_X0, 64'd0, 64'd0, 64'd0));
        cycle();
        idle();
        bus.wb_en = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 64'hDEAD;
        cycle();
        bus.wb_en = 1'b0;
        present(64'h48, I_ADD_X10_X7);
        exp_q.push_back(mk(64'h48, I_ADD_X10_X7, 64'd0, 64'd0, 64'h1234));
        cycle();
        idle();
        drain(5);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bypass_drain pending=%0d required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_load_use();
        present(64'h80, I_LD_X5);
        exp_q.push_back(mk(64'h80, I_LD_X5, 64'd0, 64'd0, 64'd0));
        cycle();
        present(64'h84, I_ADD_X6_X5);
        exp_q.push_back(mk(64'h84, I_ADD_X6_X5, 64'd0, 64'd0, 64'd0));
        cycle();
        n_tests++;
        if (bus.hazard_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL lu_stall got=%b required 1", bus.hazard_stall);
        end
        // Fetch holds the next instruction for as long as the stall lasts.
        present(64'h88, I_ADDI_X11);
        exp_q.push_back(mk(64'h88, I_ADDI_X11, 64'd11, 64'd0, 64'd0));
        cycle();
        n_tests++;
        if (bus.ex_valid !== 1'b0 || bus.hazard_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL lu_bubble ex_valid=%b stall=%b required 0 0",
                     bus.ex_valid, bus.hazard_stall);
        end
        cycle();
        idle();
        n_tests++;
        if (bus.ex_valid !== 1'b1 || bus.ex_rs1 !== 5'd5 || bus.ex_pc !== 64'h84) begin
            n_fail++;
            $display("FAIL lu_issue ex_valid=%b ex_rs1=%0d ex_pc=%h required 1 5 84",
                     bus.ex_valid, bus.ex_rs1, bus.ex_pc);
        end
        drain(5);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL lu_drain pending=%0d required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_flush_priority();
        present(64'hC0, I_LD_X5);
        exp_q.push_back(mk(64'hC0, I_LD_X5, 64'd0, 64'd0, 64'd0));
        cycle();
        present(64'hC4, I_ADD_X6_X5);
        cycle();
        n_tests++;
        if (bus.hazard_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL fl_prestall got=%b required 1", bus.hazard_stall);
        end
        bus.flush = 1'b1;
        present(64'hC8, I_ADDI_X11);
        cycle();
        bus.flush = 1'b0;
        idle();
        n_tests++;
        if (bus.ex_valid !== 1'b0 || bus.hazard_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL fl_after ex_valid=%b stall=%b required 0 0",
                     bus.ex_valid, bus.hazard_stall);
        end
        cycle();
        n_tests++;
        if (bus.ex_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fl_ifid_killed ex_valid=%b required 0", bus.ex_valid);
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL fl_drain pending=%0d required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins;
        for (int i = 0; i < 8; i++) begin
            if (i < 7) begin
                ins = ((i + 10) << 20) | ((i + 10) << 7) | 32'h13; // addi x(10+i),x0,10+i
                present(64'(i * 4), ins);
                exp_q.push_back(mk(64'(i * 4), ins, 64'(i + 10), 64'd0, 64'd0));
            end else begin
                idle();
            end
            cycle();
            if (i >= 1) begin
                n_tests++;
                if (bus.ex_valid !== 1'b1 || bus.ex_pc !== 64'((i - 1) * 4)) begin
                    n_fail++;
                    $display("FAIL b2b_step%0d ex_valid=%b ex_pc=%h required 1 %h",
                             i, bus.ex_valid, bus.ex_pc, 64'((i - 1) * 4));
                end
            end
        end
        drain(4);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_drain pending=%0d required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        sb_on   = 1'b0;
        rst     = 1'b1;
        bus.if_pc          = '0;
        bus.if_instruction = '0;
        bus.if_valid       = 1'b0;
        bus.flush          = 1'b0;
        bus.wb_en          = 1'b0;
        bus.wb_rd          = '0;
        bus.wb_data        = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_immediates();
        test_bypass_x0();
        test_load_use();
        test_flush_priority();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout tests=%0d required completion", n_tests);
        $fatal(1, "bench timeout");
    end

endmodule
`default_nettype wire

// File: doc/decode_stage.md
# decode_stage

Instruction-decode stage of the pipelined RV64 core. It sits directly downstream of `Fetch` and contains three parts: the IF/ID pipeline latch, the register-file read with write-back bypass and immediate generation, and the ID/EX output register. It also detects load-use hazards, stalls fetch when one occurs, and honours flushes from the execute stage.

## Interface
Parameters:
- `XLEN`, 64: datapath width.
- `NREGS`, 32: architectural register count; x0 is hardwired to zero.

Ports (clock and reset first):
- `Clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `if_pc` in XLEN: PC of the instruction currently presented by Fetch.
- `if_instruction` in 32: instruction word from Fetch.
- `if_valid` in 1: fetch output is meaningful.
- `flush` in 1: taken branch/jump resolved in EX; kill younger instructions.
- `wb_en` in 1: write-back enable.
- `wb_rd` in 5: write-back destination register.
- `wb_data` in XLEN: write-back value.
- `hazard_stall` out 1: combinational; Fetch must hold `pc_next` while this is high.
- `ex_valid` out 1: ID/EX holds a real instruction.
- `ex_pc` out XLEN.
- `ex_rs1_data`, `ex_rs2_data` out XLEN.
- `ex_imm` out XLEN: sign-extended immediate.
- `ex_rs1`, `ex_rs2`, `ex_rd` out 5.
- `ex_opcode` out 7.
- `ex_funct3` out 3.
- `ex_funct7b5` out 1: instruction bit 30.
- `ex_mem_read` out 1: opcode is LOAD (0000011).

## Operation
- **IF/ID latch**
  - Captures `if_pc`, `if_instruction` and `if_valid` each edge unless `hazard_stall` is high, in which case it holds.
  - When `flush` is high, the IF/ID valid bit is cleared.
  - Flush has priority over stall.
- **Decode** (combinational from IF/ID):
  - rs1 = [19:15], rs2 = [24:20], rd = [11:7].
  - Immediate by opcode:
    - I-type (0000011, 0010011, 0011011, 1100111): [31:20].
    - S-type (0100011): {[31:25],[11:7]}.
    - B-type (1100011): {[31],[7],[30:25],[11:8],0}.
    - U-type (0110111, 0010111): {[31:12],12'b0}.
    - J-type (1101111): {[31],[19:12],[20],[30:21],0}.
    - Every immediate is sign-extended from its top bit to XLEN. All other opcodes produce imm = 0.
- **Register file**
  - 2 read ports, 1 write port.
  - Writes on the edge when `wb_en` is high and `wb_rd` != 0; writes to x0 are dropped.
  - Reads of x0 return 0.
  - Same-cycle bypass: if `wb_en` is high, `wb_rd` != 0 and `wb_rd` matches the read address, the read returns `wb_data`.
- **Load-use hazard**
  - `hazard_stall` = IF/ID valid && `ex_valid` && `ex_mem_read` && `ex_rd` != 0 && (`ex_rd` == rs1 || (`ex_rd` == rs2 && opcode ∈ {0110011, 0111011, 0100011, 1100011})).
- **ID/EX register**
  - On flush or stall: `ex_valid` ← 0 (bubble); the other fields may update but are don't-care while `ex_valid` = 0.
  - Otherwise: loads all decoded fields, with `ex_valid` ← IF/ID valid.

## Timing
- Reset values:
  - All `ex_*` outputs are 0.
  - IF/ID valid, PC and instruction are 0.
  - All registers are 0.
  - `hazard_stall` is 0.
- Reset asserted mid-operation clears state immediately (asynchronously), with no wait for an edge.
- Latency: an instruction presented by Fetch in cycle N is in IF/ID after edge N and appears on `ex_*` after edge N+1.
- A load-use pair costs exactly one bubble. `hazard_stall` falls in the cycle after the bubble is inserted, because the load has then advanced past ID/EX.
- `flush` while `hazard_stall` is high: both stages are emptied at that edge, and `hazard_stall` is 0 in the next cycle.
- A write-back in the same cycle as a read of the same register returns the new value, with no extra latency.

## Structure
- Shared package `rv_pkg`:
  - opcode constants (OP_LOAD, OP_IMM, OP_IMM32, OP_JALR, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_REG, OP_REG32);
  - `imm_type_t` enum (I, S, B, U, J, NONE);
  - XLEN.
- One natural sub-module: `reg_file` (NREGS×XLEN, 2R1W, x0 hardwired, internal write-back bypass), with `Clk`/`reset` shared.
- Immediate generation and hazard detection stay inline.

## Test plan
- **Reset:** assert `reset` mid-stream → all `ex_*` = 0 and `hazard_stall` = 0 at once; `x5` reads 0 afterwards.
- **Immediates:**
  - `addi x1,x0,-1` (0xFFF00093) → `ex_imm` = 0xFFFFFFFFFFFFFFFF, `ex_rd` = 1;
  - `sd x2,8(x1)` → `ex_imm` = 8;
  - `beq` offset −4 → `ex_imm` = −4;
  - `lui x3,0x80000` → `ex_imm` = 0xFFFFFFFF80000000.
- **Bypass and x0:**
  - `wb_en` = 1, `wb_rd` = 7, `wb_data` = 0x1234, same cycle as decode of `add x8,x7,x0` → `ex_rs1_data` = 0x1234, `ex_rs2_data` = 0;
  - a write-back to x0 of 0xDEAD → x0 still reads 0.
- **Load-use:** `ld x5,0(x1)` followed by `add x6,x5,x2` → `hazard_stall` = 1 for one cycle, one `ex_valid` = 0 bubble, then the add issues with `ex_rs1` = 5.
- **Flush priority:** `flush` = 1 together with `hazard_stall` = 1 → next cycle `ex_valid` = 0, IF/ID invalid, `hazard_stall` = 0.
- **Throughput:** seven back-to-back independent instructions at PC 0, 4, …, 24 → `ex_pc` steps by 4 each cycle with no bubbles, first one appearing two edges after it is presented.
